// File: rtl/boot_pkg.sv
// Shared encodings for the boot loader: FSM states and the default text base.
package boot_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/boot_loader_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_valid_o pulses
// combinationally alongside the 4th byte of each word.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (byte_valid_i) begin
            lane_d  = lane_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            lane_q  <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
    assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: length-prefixed image into instruction memory, CPU
// held in reset until loaded. Optional trailing checksum under BOOT_CHECKSUM_EN.
module boot_loader
    import boot_pkg::*;
#(
    parameter int          IM_DEPTH  = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic [31:0]       boot_pc,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    localparam logic [15:0]   DEPTH16 = 16'(IM_DEPTH);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);
`ifdef BOOT_CHECKSUM_EN
    localparam state_e S_AFTER_DATA = S_CSUM;
`else
    localparam state_e S_AFTER_DATA = S_DONE;
`endif

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        csum_sum;
`endif

    logic        accept;
    logic        data_acc;
    logic [15:0] n_full;
    logic [31:0] pk_word;
    logic        pk_valid;

    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept   = in_valid && in_ready;
    assign data_acc = accept && (state_q == S_DATA);
    assign n_full   = {len_hi_q, in_data};

    word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (state_q == S_LEN_HI),
        .byte_valid_i (data_acc),
        .byte_i       (in_data),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

`ifdef BOOT_CHECKSUM_EN
    assign csum_sum = csum_q + in_data;
`endif

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        idx_d      = idx_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_LEN_HI: if (accept) begin
                len_hi_d = in_data;
                state_d  = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d = n_full;
                if (n_full > DEPTH16)      state_d = S_ERR;
                else if (n_full == 16'd0)  state_d = S_AFTER_DATA;
                else                       state_d = S_DATA;
            end
            S_DATA: begin
`ifdef BOOT_CHECKSUM_EN
                if (data_acc) csum_d = csum_sum;
`endif
                if (pk_valid) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = idx_q[ADDR_W-1:0];
                    im_wdata_d = pk_word;
                    idx_d      = idx_q + IDX_ONE;
                    // idx_q is pre-increment, so +1 is the count including this word
                    if ((16'(idx_q) + 16'd1) == len_q) state_d = S_AFTER_DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: if (accept) begin
                state_d = (csum_sum == 8'h00) ? S_DONE : S_ERR;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LEN_HI;
            len_hi_q   <= 8'd0;
            len_q      <= 16'd0;
            idx_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_rst  = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign boot_pc  = TEXT_BASE;
    assign word_cnt = {{(15-ADDR_W){1'b0}}, idx_q};

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader; checksum scenarios follow BOOT_CHECKSUM_EN.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic [31:0] boot_pc;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    int errors = 0;
    int checks = 0;
    int we_total = 0;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    boot_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .boot_pc  (boot_pc),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    // Edge-triggered memory model, as the real instruction memory behaves
    always @(posedge clk) begin
        if (im_we) begin
            mem[im_addr] <= im_wdata;
            we_total     <= we_total + 1;
        end
    end

    function automatic logic [31:0] img_word(input int i);
        return 32'h2001_0001 + i;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL reset_im_we got=%b exp=0", im_we); end
        checks++; if (im_addr !== 10'd0) begin errors++; $display("FAIL reset_im_addr got=%0d exp=0", im_addr); end
        checks++; if (im_wdata !== 32'd0) begin errors++; $display("FAIL reset_im_wdata got=%h exp=0", im_wdata); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        checks++; if (boot_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_boot_pc got=%h exp=00003000", boot_pc); end
        rst = 1'b0;
    endtask

    // Streams the 35-word image; gap idle cycles follow every byte
    task automatic test_stream(input int gap);
        logic [31:0] w;
        logic [7:0]  sum;
        int          base;
        sum = 8'd0;
        pulse_reset();
        base = we_total;
        send_byte(8'h00);
        send_byte(8'd35);
        for (int i = 0; i < 35; i++) begin
            w = img_word(i);
            for (int b = 0; b < 4; b++) begin
                sum = sum + w[31-8*b -: 8];
                send_byte(w[31-8*b -: 8]);
                if (b < 3) begin
                    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL stray_we gap=%0d word=%0d byte=%0d got=%b exp=0", gap, i, b, im_we); end
                end else begin
                    checks++;
                    if (im_we !== 1'b1 || im_addr !== 10'(i) || im_wdata !== w || word_cnt !== 16'(i + 1)) begin
                        errors++;
                        $display("FAIL word_write gap=%0d idx=%0d got we=%b a=%0d d=%h cnt=%0d exp we=1 a=%0d d=%h cnt=%0d",
                                 gap, i, im_we, im_addr, im_wdata, word_cnt, i, w, i + 1);
                    end
`ifdef BOOT_CHECKSUM_EN
                    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL cpu_rst_early gap=%0d idx=%0d got=%b exp=1", gap, i, cpu_rst); end
`else
                    checks++;
                    if (cpu_rst !== (i != 34) || done !== (i == 34)) begin
                        errors++;
                        $display("FAIL release gap=%0d idx=%0d got cpu_rst=%b done=%b exp cpu_rst=%b done=%b", gap, i, cpu_rst, done, i != 34, i == 34);
                    end
`endif
                end
                for (int g = 0; g < gap; g++) begin
                    idle_cycle();
                    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL gap_we gap=%0d word=%0d got=%b exp=0", gap, i, im_we); end
                end
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00 - sum);
`endif
        idle_cycle();
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0 || word_cnt !== 16'd35) begin
            errors++;
            $display("FAIL stream_end gap=%0d got done=%b cpu_rst=%b rdy=%b err=%b cnt=%0d exp 1 0 0 0 35", gap, done, cpu_rst, in_ready, err, word_cnt);
        end
        checks++; if (we_total - base !== 35) begin errors++; $display("FAIL stream_writes gap=%0d got=%0d exp=35", gap, we_total - base); end
        for (int i = 0; i < 35; i++) begin
            checks++; if (mem[i] !== img_word(i)) begin errors++; $display("FAIL mem gap=%0d addr=%0d got=%h exp=%h", gap, i, mem[i], img_word(i)); end
        end
    endtask

    task automatic test_len_overflow();
        int base;
        pulse_reset();
        base = we_total;
        send_byte(8'h04);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_early_err got=%b exp=0", err); end
        send_byte(8'h01);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_state got err=%b rdy=%b cpu_rst=%b done=%b exp 1 0 1 0", err, in_ready, cpu_rst, done);
        end
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
        idle_cycle();
        checks++; if (we_total - base !== 0 || word_cnt !== 16'd0) begin errors++; $display("FAIL ovf_writes got=%0d cnt=%0d exp=0 0", we_total - base, word_cnt); end
        checks++; if (err !== 1'b1 || cpu_rst !== 1'b1) begin errors++; $display("FAIL ovf_sticky got err=%b cpu_rst=%b exp 1 1", err, cpu_rst); end
        // Exactly IM_DEPTH words is a legal length
        pulse_reset();
        send_byte(8'h04);
        send_byte(8'h00);
        checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL len_max got err=%b rdy=%b exp 0 1", err, in_ready); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        int base;
        pulse_reset();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        checks++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL csum_wait got cpu_rst=%b done=%b exp 1 0", cpu_rst, done); end
        send_byte(8'hF6);
        checks++; if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin errors++; $display("FAIL csum_good got done=%b err=%b cpu_rst=%b exp 1 0 0", done, err, cpu_rst); end
        pulse_reset();
        base = we_total;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF5);
        checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL csum_bad got err=%b done=%b cpu_rst=%b exp 1 0 1", err, done, cpu_rst); end
        checks++; if (we_total - base !== 1) begin errors++; $display("FAIL csum_bad_writes got=%0d exp=1", we_total - base); end
    endtask
`endif

    task automatic test_reset_mid_load();
        int base;
        logic [31:0] w;
        pulse_reset();
        send_byte(8'h00);
        send_byte(8'h05);
        for (int i = 0; i < 2; i++) begin
            w = 32'h1111_0000 + i;
            for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8]);
        end
        pulse_reset();
        checks++;
        if (word_cnt !== 16'd0 || done !== 1'b0 || in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state got cnt=%0d done=%b rdy=%b cpu_rst=%b exp 0 0 1 1", word_cnt, done, in_ready, cpu_rst);
        end
        base = we_total;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'hC8);
`endif
        idle_cycle();
        checks++; if (we_total - base !== 1) begin errors++; $display("FAIL midrst_writes got=%0d exp=1", we_total - base); end
        checks++; if (mem[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midrst_mem0 got=%h exp=deadbeef", mem[0]); end
        checks++; if (mem[1] !== 32'h1111_0001) begin errors++; $display("FAIL midrst_mem1_kept got=%h exp=11110001", mem[1]); end
        checks++; if (word_cnt !== 16'd1 || done !== 1'b1) begin errors++; $display("FAIL midrst_done got cnt=%0d done=%b exp 1 1", word_cnt, done); end
    endtask

    task automatic test_len_zero();
        int base;
        pulse_reset();
        base = we_total;
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
        checks++; if (cpu_rst !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL zero_csum_wait got cpu_rst=%b rdy=%b exp 1 1", cpu_rst, in_ready); end
        send_byte(8'h00);
`endif
        checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b cpu_rst=%b err=%b exp 1 0 0", done, cpu_rst, err); end
        idle_cycle();
        checks++; if (we_total - base !== 0 || word_cnt !== 16'd0) begin errors++; $display("FAIL zero_writes got=%0d cnt=%0d exp 0 0", we_total - base, word_cnt); end
    endtask

    initial begin
        test_reset();
        test_stream(0);
        test_stream(2);
        test_len_overflow();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        test_len_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Upstream feeder for the single-cycle CPU. Accepts a byte stream (e.g. from a UART receiver), assembles big-endian 32-bit instruction words, and writes them into instruction memory starting at word 0, which corresponds to TEXT_BASE_ADDRESS. Holds the CPU in reset until the whole image has been written, then releases it. This replaces the simulation-only image load step for hardware runs.

## Interface
- IM_DEPTH, 1024: instruction memory depth in words.
- ADDR_W, 10: word-address width; clog2(IM_DEPTH).
- TEXT_BASE, 32'h0000_3000: byte address of IM word 0; reported on `boot_pc`.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; one clock domain.
- in_data  in  8  stream byte.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  loader can accept a byte.
- im_we  out  1  instruction memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  word index of the write.
- im_wdata  out  32  instruction word.
- cpu_rst  out  1  reset to the CPU; high until the load completes.
- boot_pc  out  32  constant TEXT_BASE.
- done  out  1  image loaded (sticky).
- err  out  1  load failed (sticky).
- word_cnt  out  16  words written so far.

## Operation
- A byte transfers on a clock edge when `in_valid && in_ready`.
- Frame layout: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes, each word MSB first, then one checksum byte if BOOT_CHECKSUM_EN is defined.
- States:
  - S_LEN_HI: accept a byte, go to S_LEN_LO.
  - S_LEN_LO:
    - If N > IM_DEPTH, go to S_ERR.
    - If N == 0, go to S_CSUM (with checksum) or S_DONE (without).
    - Otherwise go to S_DATA.
  - S_DATA: accept 4·N bytes. On every 4th byte, issue a word write. After word N, go to S_CSUM or S_DONE.
  - S_CSUM: accept one byte. Go to S_DONE on match, S_ERR on mismatch.
  - S_DONE, S_ERR: terminal. Only `rst` leaves them.
- `in_ready` = 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM. It is 0 in S_DONE and S_ERR.
- The byte lane counter is 2 bits and wraps 3→0. The word index counter is ADDR_W+1 bits wide, so index == IM_DEPTH does not alias to 0.
- `cpu_rst` = 1 in every state except S_DONE. In S_ERR the CPU stays in reset.
- `done` = (state == S_DONE). `err` = (state == S_ERR).
- Reset values:
  - state = S_LEN_HI
  - in_ready = 1
  - im_we = 0, im_addr = 0, im_wdata = 0
  - cpu_rst = 1, done = 0, err = 0, word_cnt = 0
  - checksum accumulator = 0
- Reset mid-load: the frame is abandoned and the next byte is treated as LEN_HI. Words already written remain in memory.
- Bytes arriving while `in_ready` = 0 are ignored and never stall upstream.

## Timing
- `im_we`, `im_addr` and `im_wdata` are registered. They are valid for exactly one cycle, on the cycle after the 4th byte of a word is accepted.
- `word_cnt` increments in the same cycle that `im_we` is high.
- There is no backpressure during writes. Back-to-back bytes on every cycle are sustained, with a maximum throughput of 1 word per 4 cycles.
- Final data byte accepted at edge k (no checksum):
  - `im_we` is high for cycle k+1.
  - The state is S_DONE from edge k, so `done` = 1 and `cpu_rst` = 0 from cycle k+1. The CPU's first active edge coincides with the last memory write.
- The instruction memory write is edge-triggered, so the last word is committed at edge k+1, before the CPU's first fetch after reset.
- Error detection (length or checksum) takes effect on the cycle after the offending byte is accepted.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - S_CSUM is present.
  - Checksum = 8-bit sum, mod 256, of all data bytes. The length bytes are excluded.
  - The trailing byte must equal its two's complement, so sum + trailer == 8'h00.
  - Mismatch goes to S_ERR.
- BOOT_CHECKSUM_EN not defined:
  - No S_CSUM and no accumulator.
  - `err` is caused only by length overflow.

## Structure
- Package `boot_pkg`: state encoding (S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR) and the default TEXT_BASE constant.
- Sub-module `word_packer`:
  - Contains the 2-bit lane counter and a 24-bit shift register.
  - Emits a 32-bit word plus a one-cycle `word_valid`.
  - Is cleared by `rst` and by the top when in S_LEN_HI.
- Top-level contents: FSM, word index counter, checksum, and output registers.

## Test plan
- N = 35 words 0x20010001…0x20010023, streamed every cycle with a correct checksum → 35 `im_we` pulses, addresses 0..34 with matching data, `done` = 1, `cpu_rst` falls the cycle after the last pulse, `word_cnt` = 35.
- Same image with `in_valid` toggling 1,0,0,1 → identical memory contents, and no write on cycles without a completed word.
- Length 0x0401 with IM_DEPTH = 1024 → `err` = 1 the cycle after LEN_LO, zero writes, `in_ready` = 0, `cpu_rst` held at 1.
- BOOT_CHECKSUM_EN, N = 1, word 0x01020304, trailer 0xF6 → `done`. With trailer 0xF5 → `err`, and `cpu_rst` stays 1.
- `rst` pulsed after 2 of 5 words, then a fresh N = 1 frame with word 0xDEADBEEF → a single write to address 0 with 0xDEADBEEF, `word_cnt` = 1, `done`.
- N = 0 (without checksum) → `done` and `cpu_rst` = 0 on the cycle after LEN_LO, with no writes.
